// File: rtl/neopixel_frame_ctrl_if.sv
// Fetch port to the pixel store plus value/valid/busy handshake to the bit writer.
// The frame sequencer is the master on both; the store and writer sit behind the slave side.
interface neopixel_frame_ctrl_if;
   logic [7:0]  pix_addr;
   logic        pix_req;
   logic [23:0] pix_data;
   logic        bit_value;
   logic        bit_valid;
   logic        bit_busy;

   modport master (
      output pix_addr, pix_req, bit_value, bit_valid,
      input  pix_data, bit_busy
   );

   modport slave (
      input  pix_addr, pix_req, bit_value, bit_valid,
      output pix_data, bit_busy
   );
endinterface

// File: rtl/neopixel_frame_ctrl.sv
// NeoPixel frame sequencer: fetches NUM_PIXELS GRB words, feeds them MSB-first to the
// single-bit writer one handshake at a time, then holds the line low for the latch period.
module neopixel_frame_ctrl #(
   parameter int NUM_PIXELS  = 8,           // 1..255
   parameter int CLK_HZ      = 12_000_000,
   parameter int RESET_US    = 80,          // must give at least one latch cycle
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic                 start,
   neopixel_frame_ctrl_if.master np,
   output logic                 frame_busy,
   output logic                 frame_done,
   output logic                 err
);

   localparam int LATCH_CYCLES = (CLK_HZ / 1_000_000) * RESET_US;
   localparam int TMO_W        = $clog2(ACK_TIMEOUT + 1);
   localparam int LAT_W        = $clog2(LATCH_CYCLES + 1);

   localparam logic [7:0]       LAST_PIX = 8'(NUM_PIXELS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SEND,
      WAIT_ACK,
      WAIT_DONE,
      LATCH,
      DONE
   } state_t;

   state_t           state, state_d;
   logic [7:0]       pix_cnt, pix_cnt_d;
   logic [4:0]       bit_cnt, bit_cnt_d;
   logic [23:0]      shift, shift_d;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
   logic [LAT_W-1:0] lat_cnt, lat_cnt_d;

   // The MSB of the shift register is the bit on the wire: it changes only on entry
   // to SEND, so bit_value is a flop output that holds until the next bit is issued.
   assign np.bit_value = shift[23];

   // NOTE: every output and next-state variable gets a default before the case so no
   // path through the block leaves one unassigned, which would infer a latch.
   always_comb begin
      state_d      = state;
      pix_cnt_d    = pix_cnt;
      bit_cnt_d    = bit_cnt;
      shift_d      = shift;
      tmo_cnt_d    = tmo_cnt;
      lat_cnt_d    = lat_cnt;
      np.pix_req   = 1'b0;
      np.pix_addr  = '0;
      np.bit_valid = 1'b0;
      err          = 1'b0;
      frame_done   = 1'b0;
      frame_busy   = (state != IDLE);

      case (state)
         IDLE: begin
            if (start) begin
               pix_cnt_d = '0;
               state_d   = FETCH;
            end
         end

         FETCH: begin
            np.pix_req  = 1'b1;
            np.pix_addr = pix_cnt;
            state_d     = LOAD;
         end

         // The store answers one cycle after pix_req, so pix_data is looked at only here.
         LOAD: begin
            shift_d   = np.pix_data;
            bit_cnt_d = 5'd23;
            state_d   = SEND;
         end

         SEND: begin
            np.bit_valid = 1'b1;
            tmo_cnt_d    = '0;
            state_d      = WAIT_ACK;
         end

         WAIT_ACK: begin
            if (np.bit_busy) begin
               state_d = WAIT_DONE;
            end else if (tmo_cnt == TMO_LAST) begin
               err     = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt + TMO_W'(1);
            end
         end

         WAIT_DONE: begin
            if (!np.bit_busy) begin
               if (bit_cnt != 5'd0) begin
                  shift_d   = {shift[22:0], 1'b0};
                  bit_cnt_d = bit_cnt - 5'd1;
                  state_d   = SEND;
               end else if (pix_cnt != LAST_PIX) begin
                  pix_cnt_d = pix_cnt + 8'd1;
                  state_d   = FETCH;
               end else begin
                  lat_cnt_d = '0;
                  state_d   = LATCH;
               end
            end
         end

         LATCH: begin
            if (lat_cnt == LAT_LAST) begin
               state_d = DONE;
            end else begin
               lat_cnt_d = lat_cnt + LAT_W'(1);
            end
         end

         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // values from before the edge, independent of statement order.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state   <= IDLE;
         pix_cnt <= '0;
         bit_cnt <= '0;
         // NOTE: the shift register is reset too, because its MSB drives bit_value
         // and that output must read 0 while reset is held.
         shift   <= '0;
         tmo_cnt <= '0;
         lat_cnt <= '0;
      end else begin
         state   <= state_d;
         pix_cnt <= pix_cnt_d;
         bit_cnt <= bit_cnt_d;
         shift   <= shift_d;
         tmo_cnt <= tmo_cnt_d;
         lat_cnt <= lat_cnt_d;
      end
   end

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Bench for neopixel_frame_ctrl: pixel-store and bit-writer models on the falling edge,
// a table of whole-frame vectors, and hand-written start-ignore and mid-frame reset sequences.
module tb_neopixel_frame_ctrl;

   localparam int NUM_PIXELS   = 2;
   localparam int CLK_HZ       = 12_000_000;
   localparam int RESET_US     = 2;
   localparam int ACK_TIMEOUT  = 64;
   localparam int LATCH_CYCLES = 24;    // 12 cycles per us * 2 us
   localparam int HOLD         = 10;    // writer busy time per bit
   localparam int BUDGET       = 4000;
   localparam logic [23:0] GARBAGE = 24'h5A3C96;

   typedef struct {
      string       name;
      logic [23:0] p0;
      logic [23:0] p1;
      int          dly;        // writer busy delay after valid; -1 = never acknowledges
      int          exp_bits;
      int          exp_done;
      int          exp_err;
   } vec_t;

   logic        CLK   = 1'b0;
   logic        RSTN  = 1'b0;
   logic        start = 1'b0;
   logic        frame_busy, frame_done, err;
   logic [23:0] pix_data_r = GARBAGE;
   logic        bit_busy_r = 1'b0;

   neopixel_frame_ctrl_if np_if ();

   assign np_if.pix_data = pix_data_r;
   assign np_if.bit_busy = bit_busy_r;

   neopixel_frame_ctrl #(
      .NUM_PIXELS (NUM_PIXELS),
      .CLK_HZ     (CLK_HZ),
      .RESET_US   (RESET_US),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .start     (start),
      .np        (np_if.master),
      .frame_busy(frame_busy),
      .frame_done(frame_done),
      .err       (err)
   );

   always #5 CLK = ~CLK;

   // Store contents and writer behaviour, set by the stimulus process.
   logic [23:0] mem [NUM_PIXELS];
   int          wdly = 3;

   // Model and monitor state, owned by the falling-edge process.
   int         nc = 0;
   bit         pend = 1'b0;
   logic [7:0] paddr = '0;
   int         dcnt = 0;
   int         hcnt = 0;
   bit         armed = 1'b0;
   int         proto_viol = 0;
   logic       bits_q[$];
   int         valid_nc[$];
   int         err_nc[$];
   int         done_nc[$];
   int         fall_nc[$];
   int         req_addr[$];

   always @(negedge CLK) begin
      nc = nc + 1;
      // Store: data valid for exactly the cycle after pix_req, garbage otherwise.
      pix_data_r = (pend && int'(paddr) < NUM_PIXELS) ? mem[paddr] : GARBAGE;
      pend  = np_if.pix_req;
      paddr = np_if.pix_addr;
      if (np_if.pix_req) req_addr.push_back(int'(np_if.pix_addr));
      if (np_if.bit_valid) begin
         bits_q.push_back(np_if.bit_value);
         valid_nc.push_back(nc);
         if (armed) proto_viol++;
         armed = 1'b1;
      end
      if (err) begin
         err_nc.push_back(nc);
         armed = 1'b0;
      end
      if (!RSTN) armed = 1'b0;
      if (frame_done) done_nc.push_back(nc);
      // Writer
      if (np_if.bit_valid && wdly >= 0) begin
         if (wdly == 0) begin
            bit_busy_r = 1'b1;
            hcnt       = HOLD;
         end else begin
            dcnt = wdly;
         end
      end else if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) begin
            bit_busy_r = 1'b1;
            hcnt       = HOLD;
         end
      end else if (hcnt > 0) begin
         hcnt--;
         if (hcnt == 0) begin
            bit_busy_r = 1'b0;
            fall_nc.push_back(nc);
            armed = 1'b0;
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge CLK); #1 start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
   endtask

   task automatic wait_end(input int db, input int eb, output int used);
      used = 0;
      while (done_nc.size() == db && err_nc.size() == eb && used < BUDGET) begin
         @(posedge CLK);
         used++;
      end
      repeat (40) @(posedge CLK);
      #1;
   endtask

   function automatic logic [47:0] exp_seq(input logic [23:0] p0, input logic [23:0] p1, input int n);
      logic [47:0] s;
      s = '0;
      for (int k = 0; k < n && k < 48; k++) s[47-k] = (k < 24) ? p0[23-k] : p1[47-k];
      return s;
   endfunction

   function automatic logic [47:0] act_seq(input int base);
      logic [47:0] s;
      s = '0;
      for (int k = 0; k < 48 && base + k < bits_q.size(); k++) s[47-k] = bits_q[base+k];
      return s;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      vec_t v;
      int   bb, vb, rb, eb, db, pb, used, w;

      vecs[0] = '{name:"basic",    p0:24'hFF0000, p1:24'h00A5C3, dly:3,  exp_bits:48, exp_done:1, exp_err:0};
      vecs[1] = '{name:"zero_ack", p0:24'h800001, p1:24'h800001, dly:0,  exp_bits:48, exp_done:1, exp_err:0};
      vecs[2] = '{name:"timeout",  p0:24'h123456, p1:24'h654321, dly:-1, exp_bits:1,  exp_done:0, exp_err:1};
      vecs[3] = '{name:"restart",  p0:24'hC0FFEE, p1:24'h13579B, dly:5,  exp_bits:48, exp_done:1, exp_err:0};

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      check("reset_outputs",
            {np_if.pix_addr, np_if.pix_req, np_if.bit_value, np_if.bit_valid, frame_busy, frame_done, err},
            '0);
      RSTN = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      check("idle_no_activity", bits_q.size() + req_addr.size(), 0);

      // Whole-frame vectors
      for (int i = 0; i < 4; i++) begin
         v = vecs[i];
         mem[0] = v.p0;
         mem[1] = v.p1;
         wdly   = v.dly;
         bb = bits_q.size();   vb = valid_nc.size(); rb = req_addr.size();
         eb = err_nc.size();   db = done_nc.size();  pb = proto_viol;
         pulse_start();
         wait_end(db, eb, used);
         check({v.name, ":finished"}, used < BUDGET, 1);
         check({v.name, ":bits"},  bits_q.size() - bb,  v.exp_bits);
         check({v.name, ":done"},  done_nc.size() - db, v.exp_done);
         check({v.name, ":err"},   err_nc.size() - eb,  v.exp_err);
         check({v.name, ":reqs"},  req_addr.size() - rb, (v.exp_err != 0) ? 1 : NUM_PIXELS);
         for (int k = 0; rb + k < req_addr.size(); k++)
            check({v.name, ":req_addr"}, req_addr[rb+k], k);
         check({v.name, ":sequence"}, act_seq(bb), exp_seq(v.p0, v.p1, v.exp_bits));
         check({v.name, ":one_valid_per_busy"}, proto_viol - pb, 0);
         check({v.name, ":frame_busy_low"}, frame_busy, 0);
         if (v.exp_done != 0 && done_nc.size() > db && fall_nc.size() > 0)
            check({v.name, ":latch_cycles"}, done_nc[db] - fall_nc[fall_nc.size()-1], LATCH_CYCLES + 1);
         if (v.exp_err != 0 && err_nc.size() > eb && valid_nc.size() > vb)
            check({v.name, ":timeout_cycles"}, err_nc[eb] - valid_nc[vb], ACK_TIMEOUT);
      end

      // Start during pixel 1 and during DONE is ignored
      mem[0] = 24'hFF0000;
      mem[1] = 24'h00A5C3;
      wdly   = 3;
      bb = bits_q.size(); rb = req_addr.size(); db = done_nc.size(); eb = err_nc.size();
      pulse_start();
      w = 0;
      while (req_addr.size() - rb < 2 && w < BUDGET) begin
         @(posedge CLK);
         w++;
      end
      check("ign:reached_pixel1", w < BUDGET, 1);
      repeat (20) @(posedge CLK);
      pulse_start();
      w = 0;
      do begin
         @(posedge CLK);
         #1;
         w++;
      end while (!frame_done && w < BUDGET);
      check("ign:reached_done", w < BUDGET, 1);
      start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      repeat (60) @(posedge CLK);
      #1;
      check("ign:bits",       bits_q.size() - bb,  48);
      check("ign:done",       done_nc.size() - db, 1);
      check("ign:reqs",       req_addr.size() - rb, 2);
      check("ign:sequence",   act_seq(bb), exp_seq(24'hFF0000, 24'h00A5C3, 48));
      check("ign:frame_busy", frame_busy, 0);

      // Reset in pixel 1, bit 10, then a clean frame from pixel 0 bit 23
      bb = bits_q.size(); db = done_nc.size(); eb = err_nc.size();
      pulse_start();
      w = 0;
      while (bits_q.size() - bb < 38 && w < BUDGET) begin
         @(posedge CLK);
         w++;
      end
      check("rst:reached_bit10", w < BUDGET, 1);
      #3 RSTN = 1'b0;
      #1;
      check("rst:outputs_zero",
            {np_if.pix_addr, np_if.pix_req, np_if.bit_value, np_if.bit_valid, frame_busy, frame_done, err},
            '0);
      repeat (3) @(posedge CLK);
      #1 RSTN = 1'b1;
      bb = bits_q.size(); rb = req_addr.size();
      repeat (50) @(posedge CLK);
      #1;
      check("rst:no_activity", (bits_q.size() - bb) + (req_addr.size() - rb), 0);
      check("rst:no_done_err", (done_nc.size() - db) + (err_nc.size() - eb), 0);
      check("rst:frame_busy", frame_busy, 0);
      mem[0] = 24'h123456;
      mem[1] = 24'hABCDEF;
      bb = bits_q.size(); rb = req_addr.size(); db = done_nc.size(); eb = err_nc.size();
      pulse_start();
      wait_end(db, eb, used);
      check("rst:finished", used < BUDGET, 1);
      check("rst:bits", bits_q.size() - bb, 48);
      check("rst:first_addr", (req_addr.size() > rb) ? req_addr[rb] : -1, 0);
      check("rst:sequence", act_seq(bb), exp_seq(24'h123456, 24'hABCDEF, 48));
      check("rst:done", done_nc.size() - db, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/neopixel_frame_ctrl.md
Name: neopixel_frame_ctrl

Overview:
Frame sequencer for the NeoPixel PMod output path. On a start strobe it fetches NUM_PIXELS 24-bit GRB words from a pixel store, serialises each word MSB-first into the single-bit writer through its value/valid/busy handshake, then holds the line idle for the latch/reset period. It sits between the pixel buffer (RAM or registers) and the bit-level writer, and is the only source of bit requests to that writer.

Parameters:
NUM_PIXELS, 8, pixels per frame (1..255)
CLK_HZ, 12_000_000, input clock rate
RESET_US, 80, latch low time in microseconds; LATCH_CYCLES = (CLK_HZ/1_000_000)*RESET_US, which is 960 at defaults
ACK_TIMEOUT, 1024, max CLK cycles to wait for bit_busy to rise after bit_valid

Ports:
CLK  in  1  system clock; all logic on the rising edge
RSTN  in  1  reset, asynchronous, active-low
start  in  1  one-cycle strobe that begins a frame; ignored unless in IDLE
pix_addr  out  8  pixel index being fetched (0..NUM_PIXELS-1)
pix_req  out  1  one-cycle fetch strobe
pix_data  in  24  GRB word; valid exactly 1 cycle after pix_req
bit_value  out  1  bit to send (registered)
bit_valid  out  1  one-cycle strobe to the bit writer
bit_busy  in  1  writer busy (asynchronous to this FSM's timing, synchronous to CLK)
frame_busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after the latch period completes
err  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset (RSTN=0, async): state=IDLE. pix_addr, pix_req, bit_value, bit_valid, frame_busy, frame_done and err are all 0. The shift register and all counters are cleared. Reset mid-frame abandons the frame with no done or err pulse. The writer may still finish its current bit.
- States: IDLE, FETCH, LOAD, SEND, WAIT_ACK, WAIT_DONE, LATCH, DONE.
- IDLE: if start=1, go to FETCH with pixel counter=0. start in any other state has no effect and is not queued.
- FETCH (1 cycle): pix_req=1, pix_addr=pixel counter. Go to LOAD.
- LOAD (1 cycle): shift register <= pix_data, bit counter=23. Go to SEND.
- SEND (1 cycle): bit_valid=1, bit_value=shift[23]. Go to WAIT_ACK with timeout counter=0. bit_value holds until the next SEND.
- WAIT_ACK: if bit_busy=1, go to WAIT_DONE. Otherwise increment the timeout counter. When it reaches ACK_TIMEOUT-1 without bit_busy, pulse err and go to IDLE with no frame_done.
- WAIT_DONE: wait for bit_busy=0.
  - If bit counter != 0: shift left by 1, decrement the bit counter, go to SEND.
  - Else if pixel counter != NUM_PIXELS-1: increment the pixel counter, go to FETCH.
  - Else: go to LATCH with latch counter=0.
- LATCH: count LATCH_CYCLES cycles. No bit_valid is issued. Then go to DONE.
- DONE (1 cycle): frame_done=1, go to IDLE. A start in this cycle is ignored.
- Bit order: pixel 0 first; within a pixel bit 23 (G7) first, bit 0 (B0) last.
- Total bit_valid pulses per good frame = 24*NUM_PIXELS. Exactly one bit_valid per bit; never two without an intervening bit_busy 1->0 transition.
- Simultaneous events: bit_busy already high on entry to WAIT_ACK counts as the ack. bit_busy falling in the same cycle as WAIT_ACK entry is treated as high then low on successive samples; only the sampled values matter.
- Counter widths: pixel 8b, bit 5b, timeout and latch counters sized with $clog2 of the max value plus 1. No wrap in legal use.

Test Plan:
1. NUM_PIXELS=2, RESET_US=2, writer model (busy rises 3 cycles after valid, held 10 cycles); pix_data[0]=24'hFF0000, [1]=24'h00A5C3. Pulse start -> exactly 48 bit_valid; bit_value sequence is 8 ones, 16 zeros, then 00000000_10100101_11000011. Then 24 idle cycles, then one frame_done, frame_busy low.
2. Check pix_req/pix_addr -> exactly two pix_req pulses with pix_addr 0 then 1. Each is followed by LOAD the next cycle; pix_data is sampled only in that cycle.
3. Writer model never raises busy -> err pulses once, ACK_TIMEOUT cycles after the first bit_valid. No frame_done; state returns to IDLE; a new start works.
4. Pulse start during the 2nd pixel and during DONE -> ignored. Still exactly 48 bits and one frame_done.
5. Deassert RSTN mid-pixel 1 (bit 10) -> all outputs 0 immediately. After release, no activity until start; a fresh start sends the full frame from pixel 0, bit 23.
6. Writer with busy already high at the valid cycle (0-cycle ack) -> still exactly one valid per bit and a correct sequence, checked with pix_data=24'h800001.
